// File: rtl/timing_lockstep_monitor_if.sv
// Bundle of run-control, finish strobes and result signals shared between the
// self-composition top (master) and the timing lockstep monitor (slave).
interface timing_lockstep_monitor_if #(
  parameter int NCH   = 2,
  parameter int CNT_W = 16
);
  logic             start;
  logic [NCH-1:0]   valid_in;
  logic [NCH-1:0]   finish;
  logic             busy;
  logic             done;
  logic             leak;
  logic             timeout;
  logic [NCH-1:0]   mismatch_mask;
  logic [CNT_W-1:0] min_lat;
  logic [CNT_W-1:0] max_lat;
  logic [CNT_W-1:0] leak_count;

  modport master (
    output start, valid_in, finish,
    input  busy, done, leak, timeout, mismatch_mask, min_lat, max_lat, leak_count
  );

  modport slave (
    input  start, valid_in, finish,
    output busy, done, leak, timeout, mismatch_mask, min_lat, max_lat, leak_count
  );
endinterface

// File: rtl/timing_lockstep_monitor.sv
// Timing-equivalence checker for N self-composed copies of a block. Each run
// measures start-to-finish latency per active channel, then reports the spread
// between the fastest and slowest channel, timeouts and per-channel divergence.
module timing_lockstep_monitor #(
  parameter int NCH     = 2,
  parameter int CNT_W   = 16,
  parameter int TOL     = 0,
  parameter int TIMEOUT = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  timing_lockstep_monitor_if.slave      bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  // Saturating increment so the leak counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [NCH-1:0]   active;
  logic [NCH-1:0]   fin;
  logic [NCH-1:0]   fin_now;
  logic [NCH-1:0]   fin_all;
  logic             all_fin;
  logic [CNT_W-1:0] lat [NCH];

  logic             leak_q;
  logic             timeout_q;
  logic [NCH-1:0]   mask_q;
  logic [CNT_W-1:0] min_q;
  logic [CNT_W-1:0] max_q;
  logic [CNT_W-1:0] lc_q;

  logic             any_fin;
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;
  logic [NCH-1:0]   r_mask;
  logic             r_leak;

  // RUN-cycle bookkeeping: latency this cycle is cnt+1; first finish per active channel wins.
  always_comb begin
    cnt_nxt = cnt + 1'b1;
    fin_now = active & ~fin & bus.finish;
    fin_all = fin | fin_now;
    all_fin = ((fin_all & active) == active);
  end

  // Result evaluation over finished active channels, consumed in REPORT.
  always_comb begin
    r_min   = '1;
    r_max   = '0;
    any_fin = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (active[i] && fin[i]) begin
        any_fin = 1'b1;
        if (lat[i] < r_min) r_min = lat[i];
        if (lat[i] > r_max) r_max = lat[i];
      end
    end
    if (!any_fin) r_min = '0;
    r_mask = '0;
    for (int i = 0; i < NCH; i++) begin
      r_mask[i] = active[i] & (~fin[i] | ((lat[i] - r_min) > TOL_C));
    end
    r_leak = ((r_max - r_min) > TOL_C) | (timeout_q & any_fin);
  end

  // Control FSM plus latency capture and held result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      active    <= '0;
      fin       <= '0;
      for (int i = 0; i < NCH; i++) lat[i] <= '0;
      leak_q    <= 1'b0;
      timeout_q <= 1'b0;
      mask_q    <= '0;
      min_q     <= '0;
      max_q     <= '0;
      lc_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            cnt       <= '0;
            active    <= bus.valid_in;
            fin       <= '0;
            leak_q    <= 1'b0;
            timeout_q <= 1'b0;
            mask_q    <= '0;
            min_q     <= '0;
            max_q     <= '0;
            state     <= (bus.valid_in == '0) ? S_REPORT : S_RUN;
          end
        end
        S_RUN: begin
          cnt <= cnt_nxt;
          fin <= fin_all;
          for (int i = 0; i < NCH; i++) begin
            if (fin_now[i]) lat[i] <= cnt_nxt;
          end
          if (all_fin) begin
            state <= S_REPORT;
          end else if (cnt_nxt == TIMEOUT_C) begin
            state     <= S_REPORT;
            timeout_q <= 1'b1;
          end
        end
        S_REPORT: begin
          leak_q <= r_leak;
          mask_q <= r_mask;
          min_q  <= r_min;
          max_q  <= r_max;
          if (r_leak) lc_q <= sat_inc(lc_q);
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy          = (state != S_IDLE);
  assign bus.done          = (state == S_REPORT);
  assign bus.leak          = leak_q;
  assign bus.timeout       = timeout_q;
  assign bus.mismatch_mask = mask_q;
  assign bus.min_lat       = min_q;
  assign bus.max_lat       = max_q;
  assign bus.leak_count    = lc_q;

endmodule

// File: tb/tb_timing_lockstep_monitor.sv
// Bench for timing_lockstep_monitor: three instances (TOL=0/TIMEOUT=20,
// TOL=3/TIMEOUT=20, CNT_W=2/TIMEOUT=3) checked against a reference model
// through per-instance expectation queues.
module tb_timing_lockstep_monitor;

  typedef struct packed {
    logic        leak;
    logic        tmo;
    logic        busy;
    logic        done;
    logic [1:0]  mask;
    logic [15:0] min_l;
    logic [15:0] max_l;
    logic [15:0] lc;
    logic [15:0] done_at;
  } res_t;

  localparam int BUDGET = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [1:0] valid = 2'b00;
  logic [1:0] fin = 2'b00;

  int n_run = 0;
  int n_fail = 0;
  int lc0 = 0, lc1 = 0, lc2 = 0;
  res_t sb0[$];
  res_t sb1[$];
  res_t sb2[$];

  always #5 clk = ~clk;

  timing_lockstep_monitor_if #(.NCH(2), .CNT_W(16)) b0 ();
  timing_lockstep_monitor_if #(.NCH(2), .CNT_W(16)) b1 ();
  timing_lockstep_monitor_if #(.NCH(2), .CNT_W(2))  b2 ();

  assign b0.start = start_a;  assign b0.valid_in = valid;  assign b0.finish = fin;
  assign b1.start = start_a;  assign b1.valid_in = valid;  assign b1.finish = fin;
  assign b2.start = start_b;  assign b2.valid_in = valid;  assign b2.finish = fin;

  timing_lockstep_monitor #(.NCH(2), .CNT_W(16), .TOL(0), .TIMEOUT(20)) u0 (.clk(clk), .rst(rst), .bus(b0));
  timing_lockstep_monitor #(.NCH(2), .CNT_W(16), .TOL(3), .TIMEOUT(20)) u1 (.clk(clk), .rst(rst), .bus(b1));
  timing_lockstep_monitor #(.NCH(2), .CNT_W(2),  .TOL(0), .TIMEOUT(3))  u2 (.clk(clk), .rst(rst), .bus(b2));

  // Reference model: l0/l1 are the RUN-cycle latencies at which finish pulses (0 = never).
  function automatic res_t model(logic [1:0] v, int l0, int l1, int tol, int to);
    int   l[2];
    bit   f[2];
    int   fin_end, mn, mx;
    bit   allf, anyf;
    res_t r;
    r = '0;
    l[0] = l0; l[1] = l1;
    if (v == 2'b00) begin
      r.done_at = 16'd1;
      return r;
    end
    allf = 1'b1; fin_end = 0;
    for (int i = 0; i < 2; i++) begin
      if (v[i]) begin
        if (l[i] == 0 || l[i] > to) allf = 1'b0;
        else if (l[i] > fin_end) fin_end = l[i];
      end
    end
    if (!allf) fin_end = to;
    r.tmo = !allf;
    r.done_at = 16'(fin_end + 1);
    mn = 0; mx = 0; anyf = 1'b0;
    for (int i = 0; i < 2; i++) begin
      f[i] = v[i] && l[i] != 0 && l[i] <= fin_end;
      if (f[i]) begin
        if (!anyf || l[i] < mn) mn = l[i];
        if (!anyf || l[i] > mx) mx = l[i];
        anyf = 1'b1;
      end
    end
    for (int i = 0; i < 2; i++) r.mask[i] = v[i] && (!f[i] || (l[i] - mn > tol));
    r.min_l = 16'(mn);
    r.max_l = 16'(mx);
    r.leak  = (mx - mn > tol) || (r.tmo && anyf);
    return r;
  endfunction

  function automatic res_t snap(int id, int d);
    res_t r;
    r = '0;
    r.done_at = 16'(d);
    if (id == 0) begin
      r.leak = b0.leak; r.tmo = b0.timeout; r.busy = b0.busy; r.done = b0.done;
      r.mask = b0.mismatch_mask; r.min_l = b0.min_lat; r.max_l = b0.max_lat; r.lc = b0.leak_count;
    end else if (id == 1) begin
      r.leak = b1.leak; r.tmo = b1.timeout; r.busy = b1.busy; r.done = b1.done;
      r.mask = b1.mismatch_mask; r.min_l = b1.min_lat; r.max_l = b1.max_lat; r.lc = b1.leak_count;
    end else begin
      r.leak = b2.leak; r.tmo = b2.timeout; r.busy = b2.busy; r.done = b2.done;
      r.mask = b2.mismatch_mask; r.min_l = {14'd0, b2.min_lat}; r.max_l = {14'd0, b2.max_lat};
      r.lc = {14'd0, b2.leak_count};
    end
    return r;
  endfunction

  task automatic expect_pair(logic [1:0] v, int l0, int l1);
    res_t e;
    e = model(v, l0, l1, 0, 20); if (e.leak) lc0++; e.lc = 16'(lc0); sb0.push_back(e);
    e = model(v, l0, l1, 3, 20); if (e.leak) lc1++; e.lc = 16'(lc1); sb1.push_back(e);
  endtask

  task automatic expect_u2(logic [1:0] v, int l0, int l1);
    res_t e;
    e = model(v, l0, l1, 0, 3);
    if (e.leak && lc2 < 3) lc2++;
    e.lc = 16'(lc2);
    sb2.push_back(e);
  endtask

  // Runs one transaction; returns the RUN-relative cycle where done was seen (0 = never).
  task automatic drive_run(input int inst, input logic [1:0] v, input int l0, input int l1,
                           input bit hold, input bit mid_start, output int done_at, output logic busy1);
    @(negedge clk);
    if (inst == 0) start_a = 1'b1; else start_b = 1'b1;
    valid = v;
    if (hold) fin = 2'b11;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    done_at = 0; busy1 = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      if (k == 1) busy1 = (inst == 0) ? b0.busy : b2.busy;
      if (((inst == 0) ? b0.done : b2.done) === 1'b1) begin
        done_at = k;
        break;
      end
      if (!hold) begin
        fin[0] = (k == l0);
        fin[1] = (k == l1);
      end
      start_a = (mid_start && k == 2);
      @(negedge clk);
    end
    fin = 2'b00; start_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    res_t g;
    repeat (3) @(negedge clk);
    for (int id = 0; id < 3; id++) begin
      g = snap(id, 0);
      n_run++;
      if (g !== '0) begin n_fail++; $display("FAIL reset_state inst%0d got=%h exp=0", id, g); end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    res_t g, e; int d; logic bz;
    expect_pair(2'b11, 5, 5);
    drive_run(0, 2'b11, 5, 5, 1'b0, 1'b0, d, bz);
    n_run++; if (bz !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", bz); end
    g = snap(0, d); e = sb0.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL basic_tol0 got=%h exp=%h", g, e); end
    g = snap(1, d); e = sb1.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL basic_tol3 got=%h exp=%h", g, e); end
  endtask

  task automatic test_diverge();
    res_t g, e; int d; logic bz;
    expect_pair(2'b11, 5, 8);
    drive_run(0, 2'b11, 5, 8, 1'b0, 1'b0, d, bz);
    g = snap(0, d); e = sb0.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL diverge_tol0 got=%h exp=%h", g, e); end
    g = snap(1, d); e = sb1.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL diverge_tol3 got=%h exp=%h", g, e); end
  endtask

  task automatic test_single_active();
    res_t g, e; int d; logic bz;
    expect_pair(2'b01, 4, 2);
    drive_run(0, 2'b01, 4, 2, 1'b0, 1'b0, d, bz);
    g = snap(0, d); e = sb0.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL single_tol0 got=%h exp=%h", g, e); end
    g = snap(1, d); e = sb1.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL single_tol3 got=%h exp=%h", g, e); end
  endtask

  task automatic test_timeout();
    res_t g, e; int d; logic bz;
    expect_pair(2'b11, 6, 0);
    drive_run(0, 2'b11, 6, 0, 1'b0, 1'b0, d, bz);
    g = snap(0, d); e = sb0.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL timeout_one_tol0 got=%h exp=%h", g, e); end
    g = snap(1, d); e = sb1.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL timeout_one_tol3 got=%h exp=%h", g, e); end
    expect_pair(2'b11, 0, 0);
    drive_run(0, 2'b11, 0, 0, 1'b0, 1'b0, d, bz);
    g = snap(0, d); e = sb0.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL timeout_none_tol0 got=%h exp=%h", g, e); end
    g = snap(1, d); e = sb1.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL timeout_none_tol3 got=%h exp=%h", g, e); end
  endtask

  task automatic test_empty();
    res_t g, e; int d; logic bz;
    expect_pair(2'b00, 3, 3);
    drive_run(0, 2'b00, 3, 3, 1'b0, 1'b0, d, bz);
    g = snap(0, d); e = sb0.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL empty_tol0 got=%h exp=%h", g, e); end
    g = snap(1, d); e = sb1.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL empty_tol3 got=%h exp=%h", g, e); end
  endtask

  task automatic test_held_and_restart();
    res_t g, e; int d; logic bz;
    expect_pair(2'b11, 1, 1);
    drive_run(0, 2'b11, 1, 1, 1'b1, 1'b0, d, bz);
    g = snap(0, d); e = sb0.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL held_finish got=%h exp=%h", g, e); end
    sb1.delete();
    expect_pair(2'b11, 3, 6);
    drive_run(0, 2'b11, 3, 6, 1'b0, 1'b1, d, bz);
    g = snap(0, d); e = sb0.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL start_in_run_tol0 got=%h exp=%h", g, e); end
    g = snap(1, d); e = sb1.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL start_in_run_tol3 got=%h exp=%h", g, e); end
  endtask

  task automatic test_reset_midrun();
    res_t g, e; int d; logic bz;
    @(negedge clk); start_a = 1'b1; valid = 2'b11;
    @(negedge clk); start_a = 1'b0;
    repeat (3) @(negedge clk);
    n_run++;
    if (b0.busy !== 1'b1) begin n_fail++; $display("FAIL midrun_busy got=%b exp=1", b0.busy); end
    rst = 1'b1;
    #1;
    lc0 = 0; lc1 = 0; lc2 = 0;
    for (int id = 0; id < 3; id++) begin
      g = snap(id, 0); n_run++;
      if (g !== '0) begin n_fail++; $display("FAIL midrun_reset inst%0d got=%h exp=0", id, g); end
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_run++;
      if (b0.done !== 1'b0 || b0.busy !== 1'b0) begin
        n_fail++; $display("FAIL after_reset_idle done=%b busy=%b exp 0 0", b0.done, b0.busy);
      end
    end
    expect_pair(2'b11, 2, 7);
    drive_run(0, 2'b11, 2, 7, 1'b0, 1'b0, d, bz);
    g = snap(0, d); e = sb0.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL post_reset_tol0 got=%h exp=%h", g, e); end
    g = snap(1, d); e = sb1.pop_front(); n_run++;
    if (g !== e) begin n_fail++; $display("FAIL post_reset_tol3 got=%h exp=%h", g, e); end
  endtask

  task automatic test_back_to_back_saturation();
    res_t g, e; int d; logic bz;
    for (int r = 0; r < 5; r++) begin
      expect_u2(2'b11, 1, 2);
      drive_run(2, 2'b11, 1, 2, 1'b0, 1'b0, d, bz);
      g = snap(2, d); e = sb2.pop_front(); n_run++;
      if (g !== e) begin n_fail++; $display("FAIL leak_count_sat run%0d got=%h exp=%h", r, g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_diverge();
    test_single_active();
    test_timeout();
    test_empty();
    test_held_and_restart();
    test_reset_midrun();
    test_back_to_back_saturation();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

endmodule
